// File: rtl/vip_csc_frame_arbiter.sv
// Frame-granular arbiter sharing one RGB->YCbCr converter between two pixel sources.
// Optional refused-frame counters are enabled with `define CSC_ARB_DROP_CNT_EN.
module vip_csc_frame_arbiter #(
   parameter int CSC_LATENCY = 3,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_frame_vsync,
   input  logic             s0_frame_href,
   input  logic             s0_frame_clken,
   input  logic [7:0]       s0_img_red,
   input  logic [7:0]       s0_img_green,
   input  logic [7:0]       s0_img_blue,
   input  logic             s1_frame_vsync,
   input  logic             s1_frame_href,
   input  logic             s1_frame_clken,
   input  logic [7:0]       s1_img_red,
   input  logic [7:0]       s1_img_green,
   input  logic [7:0]       s1_img_blue,
   output logic             csc_frame_vsync,
   output logic             csc_frame_href,
   output logic             csc_frame_clken,
   output logic [7:0]       csc_img_red,
   output logic [7:0]       csc_img_green,
   output logic [7:0]       csc_img_blue,
   output logic [1:0]       grant,
   output logic             busy,
   output logic             post_src_id,
   output logic             frame_done,
   output logic             done_src_id
`ifdef CSC_ARB_DROP_CNT_EN
   ,
   output logic [CNT_W-1:0] s0_drop_cnt,
   output logic [CNT_W-1:0] s1_drop_cnt
`endif
);

   localparam int DW = (CSC_LATENCY < 2) ? 1 : $clog2(CSC_LATENCY + 1);
   localparam logic [DW-1:0] LAT_LD = DW'(CSC_LATENCY);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic                   vs0_q, vs1_q;
   logic                   blk0_q, blk1_q;
   logic                   last_q, last_d;
   logic [DW-1:0]          cnt_q, cnt_d;
   logic                   sel_vld, sel_id;
   logic [26:0]            src0_bus, src1_bus, csc_d, csc_q;
   logic                   id_q;
   logic [CSC_LATENCY-1:0] id_pipe_q;
   logic                   rise0, rise1, fall0, fall1;

   // A source whose vsync was already high during reset stays blocked until it goes low.
   assign rise0 = s0_frame_vsync & ~vs0_q & ~blk0_q;
   assign rise1 = s1_frame_vsync & ~vs1_q & ~blk1_q;
   assign fall0 = ~s0_frame_vsync & vs0_q;
   assign fall1 = ~s1_frame_vsync & vs1_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      sel_vld     = 1'b0;
      sel_id      = 1'b0;
      frame_done  = 1'b0;
      done_src_id = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise0 && (!rise1 || last_q)) begin
               state_d = GRANT0;
               sel_vld = 1'b1;
            end else if (rise1) begin
               state_d = GRANT1;
               sel_vld = 1'b1;
               sel_id  = 1'b1;
            end
         end
         GRANT0: begin
            sel_vld = 1'b1;
            if (fall0) begin
               state_d = DRAIN;
               cnt_d   = LAT_LD;
               last_d  = 1'b0;
            end
         end
         GRANT1: begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
            if (fall1) begin
               state_d = DRAIN;
               cnt_d   = LAT_LD;
               last_d  = 1'b1;
            end
         end
         DRAIN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DW'(1)) begin
               state_d     = IDLE;
               frame_done  = 1'b1;
               done_src_id = last_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vs0_q   <= 1'b0;
         vs1_q   <= 1'b0;
         blk0_q  <= s0_frame_vsync;
         blk1_q  <= s1_frame_vsync;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vs0_q   <= s0_frame_vsync;
         vs1_q   <= s1_frame_vsync;
         blk0_q  <= blk0_q & s0_frame_vsync;
         blk1_q  <= blk1_q & s1_frame_vsync;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign src0_bus = {s0_frame_vsync, s0_frame_href, s0_frame_clken,
                      s0_img_red, s0_img_green, s0_img_blue};
   assign src1_bus = {s1_frame_vsync, s1_frame_href, s1_frame_clken,
                      s1_img_red, s1_img_green, s1_img_blue};
   assign csc_d    = sel_vld ? (sel_id ? src1_bus : src0_bus) : '0;

   // Mux register, then the source tag follows the converter's own pipeline depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         csc_q     <= '0;
         id_q      <= 1'b0;
         id_pipe_q <= '0;
      end else begin
         csc_q        <= csc_d;
         id_q         <= sel_vld & sel_id;
         id_pipe_q[0] <= id_q;
         for (int i = 1; i < CSC_LATENCY; i++) begin
            id_pipe_q[i] <= id_pipe_q[i-1];
         end
      end
   end

   assign {csc_frame_vsync, csc_frame_href, csc_frame_clken,
           csc_img_red, csc_img_green, csc_img_blue} = csc_q;
   assign post_src_id = id_pipe_q[CSC_LATENCY-1];
   assign grant       = (state_q == GRANT0) ? 2'b01 :
                        (state_q == GRANT1) ? 2'b10 : 2'b00;
   assign busy        = (state_q != IDLE);

`ifdef CSC_ARB_DROP_CNT_EN
   logic             ref0, ref1;
   logic [CNT_W-1:0] drop0_q, drop1_q;

   // Any rise not turned into a grant this cycle is a refused frame.
   assign ref0 = rise0 & ~((state_q == IDLE) && (state_d == GRANT0));
   assign ref1 = rise1 & ~((state_q == IDLE) && (state_d == GRANT1));

   always_ff @(posedge clk) begin
      if (rst) begin
         drop0_q <= '0;
         drop1_q <= '0;
      end else begin
         if (ref0 && (drop0_q != {CNT_W{1'b1}})) drop0_q <= drop0_q + 1'b1;
         if (ref1 && (drop1_q != {CNT_W{1'b1}})) drop1_q <= drop1_q + 1'b1;
      end
   end

   assign s0_drop_cnt = drop0_q;
   assign s1_drop_cnt = drop1_q;
`endif

endmodule

// File: tb/tb_vip_csc_frame_arbiter.sv
// Scoreboard bench for vip_csc_frame_arbiter with a 3-stage converter timing model.
module tb_vip_csc_frame_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       s0_frame_vsync, s0_frame_href, s0_frame_clken;
   logic [7:0] s0_img_red, s0_img_green, s0_img_blue;
   logic       s1_frame_vsync, s1_frame_href, s1_frame_clken;
   logic [7:0] s1_img_red, s1_img_green, s1_img_blue;
   logic       csc_frame_vsync, csc_frame_href, csc_frame_clken;
   logic [7:0] csc_img_red, csc_img_green, csc_img_blue;
   logic [1:0] grant;
   logic       busy, post_src_id, frame_done, done_src_id;
`ifdef CSC_ARB_DROP_CNT_EN
   logic [1:0] s0_drop_cnt, s1_drop_cnt;
`endif

   vip_csc_frame_arbiter #(.CSC_LATENCY(3), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .s0_frame_vsync(s0_frame_vsync), .s0_frame_href(s0_frame_href),
      .s0_frame_clken(s0_frame_clken), .s0_img_red(s0_img_red),
      .s0_img_green(s0_img_green), .s0_img_blue(s0_img_blue),
      .s1_frame_vsync(s1_frame_vsync), .s1_frame_href(s1_frame_href),
      .s1_frame_clken(s1_frame_clken), .s1_img_red(s1_img_red),
      .s1_img_green(s1_img_green), .s1_img_blue(s1_img_blue),
      .csc_frame_vsync(csc_frame_vsync), .csc_frame_href(csc_frame_href),
      .csc_frame_clken(csc_frame_clken), .csc_img_red(csc_img_red),
      .csc_img_green(csc_img_green), .csc_img_blue(csc_img_blue),
      .grant(grant), .busy(busy), .post_src_id(post_src_id),
      .frame_done(frame_done), .done_src_id(done_src_id)
`ifdef CSC_ARB_DROP_CNT_EN
      , .s0_drop_cnt(s0_drop_cnt), .s1_drop_cnt(s1_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         src;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      int         cyc;
   } pix_t;

   pix_t exp_q[$];
   pix_t post_q[$];
   int   done_q[$];
   pix_t mon_e, post_e;
   int   done_e;
   int   cyc_n = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [2:0] conv_clken;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // Converter model: post_frame_clken is csc_frame_clken delayed 3 clocks.
   always @(posedge clk) begin
      if (rst) conv_clken <= 3'b000;
      else     conv_clken <= {conv_clken[1:0], csc_frame_clken};
   end

   always @(negedge clk) begin
      if (csc_frame_clken) begin
         check_eq("pix_avail", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("pix_rgb", 32'({csc_img_red, csc_img_green, csc_img_blue}),
                     32'({mon_e.r, mon_e.g, mon_e.b}));
            check_eq("pix_latency", 32'(cyc_n), 32'(mon_e.cyc));
            check_eq("pix_grant", 32'(grant), (mon_e.src != 0) ? 32'd2 : 32'd1);
            check_eq("pix_sync", 32'({csc_frame_vsync, csc_frame_href}), 32'd3);
         end
      end
      if (conv_clken[2]) begin
         check_eq("post_avail", 32'(post_q.size() != 0), 32'd1);
         if (post_q.size() != 0) begin
            post_e = post_q.pop_front();
            check_eq("post_src_id", 32'(post_src_id), 32'(post_e.src));
            check_eq("post_latency", 32'(cyc_n), 32'(post_e.cyc));
         end
      end
      if (frame_done) begin
         check_eq("done_avail", 32'(done_q.size() != 0), 32'd1);
         if (done_q.size() != 0) begin
            done_e = done_q.pop_front();
            check_eq("done_src_id", 32'(done_src_id), 32'(done_e));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic drive_src(input int s, input logic v, input logic h, input logic c,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      if (s == 0) begin
         s0_frame_vsync = v; s0_frame_href = h; s0_frame_clken = c;
         s0_img_red = r; s0_img_green = g; s0_img_blue = b;
      end else begin
         s1_frame_vsync = v; s1_frame_href = h; s1_frame_clken = c;
         s1_img_red = r; s1_img_green = g; s1_img_blue = b;
      end
   endtask

   task automatic push_pix(input int s, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
      exp_q.push_back('{s, r, g, b, cyc_n + 1});
      post_q.push_back('{s, r, g, b, cyc_n + 4});
   endtask

   // One frame: rise cycle, lines of pixels with a 2-cycle blank, then the fall cycle.
   task automatic drive_frame(input int s, input int lines, input int npix,
                              input logic [7:0] r0, input logic [7:0] g0,
                              input logic [7:0] b0, input bit granted, input bit vary);
      logic [7:0] r, g;
      if (granted) done_q.push_back(s);
      drive_src(s, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      cyc();
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < npix; p++) begin
            r = vary ? r0 + 8'(p) : r0;
            g = vary ? g0 + 8'(l) : g0;
            drive_src(s, 1'b1, 1'b1, 1'b1, r, g, b0);
            if (granted) push_pix(s, r, g, b0);
            cyc();
         end
         drive_src(s, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
         idle(2);
      end
      drive_src(s, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_q.delete();
      post_q.delete();
      done_q.delete();
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_csc"}, 32'({csc_frame_vsync, csc_frame_href, csc_frame_clken,
               csc_img_red, csc_img_green, csc_img_blue}), 32'd0);
      check_eq({tag, "_grant"}, 32'(grant), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_post_id"}, 32'(post_src_id), 32'd0);
      check_eq({tag, "_done"}, 32'({frame_done, done_src_id}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive_src(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      drive_src(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle(2);
      @(negedge clk);
      check_quiet("reset");
`ifdef CSC_ARB_DROP_CNT_EN
      check_eq("reset_drops", 32'({s0_drop_cnt, s1_drop_cnt}), 32'd0);
`endif
      cyc();
      rst = 1'b0;
      idle(2);

      // Single source, constant red pixels; frame_done three clocks after the fall cycle.
      drive_frame(0, 4, 8, 8'd255, 8'd0, 8'd0, 1'b1, 1'b0);
      @(negedge clk);
      check_eq("drain1_done", 32'(frame_done), 32'd0);
      check_eq("drain1_grant", 32'(grant), 32'd0);
      check_eq("drain1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check_eq("drain2_done", 32'(frame_done), 32'd0);
      check_eq("drain2_csc", 32'({csc_frame_vsync, csc_frame_clken, csc_img_red}), 32'd0);
      @(negedge clk);
      check_eq("drain3_done", 32'(frame_done), 32'd1);
      check_eq("drain3_src", 32'(done_src_id), 32'd0);
      idle(6);

      // Tie after reset goes to s0, the next tie to s1.
      do_reset();
      fork
         drive_frame(0, 2, 4, 8'd10, 8'd20, 8'd30, 1'b1, 1'b1);
         drive_frame(1, 2, 4, 8'd40, 8'd50, 8'd60, 1'b0, 1'b1);
      join
      idle(6);
`ifdef CSC_ARB_DROP_CNT_EN
      check_eq("tie1_s0_drop", 32'(s0_drop_cnt), 32'd0);
      check_eq("tie1_s1_drop", 32'(s1_drop_cnt), 32'd1);
`endif
      fork
         drive_frame(0, 2, 4, 8'd70, 8'd80, 8'd90, 1'b0, 1'b1);
         drive_frame(1, 2, 4, 8'd100, 8'd110, 8'd120, 1'b1, 1'b1);
      join
      idle(6);
`ifdef CSC_ARB_DROP_CNT_EN
      check_eq("tie2_s0_drop", 32'(s0_drop_cnt), 32'd1);
      check_eq("tie2_s1_drop", 32'(s1_drop_cnt), 32'd1);
`endif

      // Contention: s1 refused while s0 owns and again during drain, then granted.
      do_reset();
      fork
         drive_frame(0, 3, 8, 8'd1, 8'd2, 8'd3, 1'b1, 1'b1);
         begin
            idle(4);
            drive_frame(1, 1, 2, 8'd200, 8'd201, 8'd202, 1'b0, 1'b1);
         end
      join
      drive_frame(1, 1, 1, 8'd210, 8'd211, 8'd212, 1'b0, 1'b1);
      idle(1);
      drive_frame(1, 2, 4, 8'd33, 8'd44, 8'd55, 1'b1, 1'b1);
      idle(6);
`ifdef CSC_ARB_DROP_CNT_EN
      check_eq("cont_s0_drop", 32'(s0_drop_cnt), 32'd0);
      check_eq("cont_s1_drop", 32'(s1_drop_cnt), 32'd2);
`endif

      // Alternating sources at minimum spacing exercise the post_src_id tag.
      for (int k = 0; k < 4; k++) begin
         drive_frame(k % 2, 2, 5, 8'(16 * k), 8'(k), 8'(255 - k), 1'b1, 1'b1);
         idle(3);
      end
      idle(4);

      // Reset in the middle of an s0 line.
      drive_src(0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      cyc();
      for (int p = 0; p < 3; p++) begin
         drive_src(0, 1'b1, 1'b1, 1'b1, 8'(p + 5), 8'd6, 8'd7);
         push_pix(0, 8'(p + 5), 8'd6, 8'd7);
         cyc();
      end
      drive_src(0, 1'b1, 1'b1, 1'b1, 8'd99, 8'd98, 8'd97);
      do_reset();
      @(negedge clk);
      check_quiet("midrst");
      for (int p = 0; p < 3; p++) begin
         cyc();
         drive_src(0, 1'b1, 1'b1, 1'b1, 8'(p + 50), 8'd1, 8'd2);
      end
      cyc();
      drive_src(0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle(2);
      @(negedge clk);
      check_eq("midrst_regrant", 32'(grant), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      cyc();
      drive_src(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      idle(2);
      drive_frame(0, 1, 4, 8'd120, 8'd121, 8'd122, 1'b1, 1'b1);
      idle(6);

      // Five refused s1 frames while s0 owns a long frame.
      do_reset();
      fork
         drive_frame(0, 4, 8, 8'd60, 8'd61, 8'd62, 1'b1, 1'b1);
         begin
            idle(2);
            repeat (5) begin
               drive_frame(1, 1, 1, 8'd7, 8'd7, 8'd7, 1'b0, 1'b0);
               idle(1);
            end
         end
      join
      idle(6);
`ifdef CSC_ARB_DROP_CNT_EN
      check_eq("sat_s1_drop", 32'(s1_drop_cnt), 32'd3);
      check_eq("sat_s0_drop", 32'(s0_drop_cnt), 32'd0);
`endif

      check_eq("left_pix", 32'(exp_q.size()), 32'd0);
      check_eq("left_post", 32'(post_q.size()), 32'd0);
      check_eq("left_done", 32'(done_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
